pr_stage_skid: RTL and testbench
================================

PR_STAGE_SKID -- requirements
Module: pr_stage_skid

Interface
REQ-001 Parameter CTRL_W, default 11, width of the control bundle (RegDst..RegWrite).
REQ-002 Parameter DATA_W, default 134, width of the payload bundle (nextPc, ReadData1, ReadData2, instruction, funcode).
REQ-003 Parameter BUBBLE_CTRL, default all-zero CTRL_W value, control word presented for an empty or flushed stage.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  upstream stage holds a valid entry.
REQ-007 in_ready  output  1  stage can accept an entry this cycle.
REQ-008 in_ctrl  input  CTRL_W  upstream control bundle.
REQ-009 in_data  input  DATA_W  upstream payload bundle.
REQ-010 flush  input  1  synchronous kill of all held entries (branch/jump redirect).
REQ-011 out_valid  output  1  stage presents a valid entry.
REQ-012 out_ready  input  1  downstream accepts the presented entry.
REQ-013 out_ctrl  output  CTRL_W  control bundle of head entry, or BUBBLE_CTRL when out_valid=0.
REQ-014 out_data  output  DATA_W  payload of head entry; value undefined when out_valid=0.
REQ-015 occupancy  output  2  number of held entries, 0..2.

Function
REQ-016 Storage SHALL be two entries: head register (drives outputs) and skid register; each entry holds ctrl, data and a valid bit.
REQ-017 in_ready SHALL be a registered signal equal to NOT skid-valid; it SHALL NOT depend combinationally on out_ready.
REQ-018 Accept event = in_valid AND in_ready; drain event = out_valid AND out_ready.
REQ-019 Latency from accept to out_valid SHALL be exactly one cycle when the head is empty or drained in the accept cycle; sustained throughput SHALL be one entry per cycle with out_ready held high.
REQ-020 On a cycle with head empty or drained: head loads from skid if skid valid (skid then loads the accepted entry if any, else clears), otherwise head loads the accepted entry if any, otherwise head clears.
REQ-021 On a cycle with head valid and not drained: head holds; an accepted entry loads into skid.
REQ-022 Entries SHALL leave in acceptance order; no entry SHALL be duplicated or dropped except by flush.
REQ-023 Accept when occupancy=2 is impossible (in_ready=0); in_valid with in_ready=0 SHALL leave state unchanged.
REQ-024 flush SHALL have priority over all events: next cycle both valid bits clear, occupancy=0, in_ready=1, and any entry offered in the flush cycle is discarded.
REQ-025 A drain coinciding with flush SHALL still count as a completed transfer downstream; the stage itself ends empty.
REQ-026 out_ctrl SHALL equal BUBBLE_CTRL whenever out_valid=0, so downstream sees a NOP even if it ignores out_valid.
REQ-027 occupancy SHALL equal head-valid + skid-valid every cycle; skid-valid=1 with head-valid=0 SHALL never occur.
REQ-028 Payload registers SHALL load only on the load conditions above; they carry no reset requirement.

Reset
REQ-029 While rst_n=0, asynchronously: out_valid=0, out_ctrl=BUBBLE_CTRL, occupancy=0, in_ready=1, skid-valid=0.
REQ-030 Deassertion of rst_n mid-transfer SHALL discard all entries; first accept possible on the first posedge with rst_n=1.

Verification
REQ-031 Stream: out_ready=1, in_valid=1 with ctrl 1..8 on 8 cycles -> out_valid=1 from cycle 1, out_ctrl 1..8 in order, occupancy=1, in_ready=1 throughout.
REQ-032 Backpressure: accept A, B with out_ready=0 -> occupancy=2, in_ready=0; raise out_ready -> A then B drained on consecutive cycles, in_ready=1 after first drain.
REQ-033 Flush: occupancy=2, flush=1 with in_valid=1 entry C -> next cycle out_valid=0, out_ctrl=BUBBLE_CTRL, occupancy=0; C never appears.
REQ-034 Simultaneous: occupancy=2, out_ready=1, in_valid=1 -> in_ready=0 so no accept; next cycle occupancy=1, head=former skid, in_ready=1.
REQ-035 Async reset: assert rst_n=0 between clock edges with occupancy=2 -> outputs reach REQ-029 values immediately, before next posedge.
REQ-036 Parameters: CTRL_W=4, DATA_W=8, BUBBLE_CTRL=4'hA -> idle out_ctrl=4'hA; REQ-031..034 pass unchanged.

Source files
------------

// File: rtl/pr_stage_skid.sv
// pr_stage_skid: two-entry pipeline stage (head + skid) with registered in_ready,
// flush and bubble control word whenever the stage presents nothing.
module pr_stage_skid #(
  parameter int CTRL_W = 11,
  parameter int DATA_W = 134,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);
  logic              head_v, skid_v;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl;
  logic [DATA_W-1:0] head_data, skid_data;
  logic              acc, head_free, head_ld, skid_ld;
  always_comb begin
    acc       = in_valid & in_ready;
    head_free = ~head_v | out_ready;
    head_ld   = ~flush & head_free & (skid_v | acc);
    skid_ld   = ~flush & acc & ~head_free;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (flush) begin
      head_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (head_free) begin
      head_v <= skid_v | acc;
      skid_v <= 1'b0;
    end else begin
      skid_v <= skid_v | acc;
    end
  // payload carries no reset; only the valid bits define occupancy
  always_ff @(posedge clk) begin
    if (head_ld) begin
      head_ctrl <= skid_v ? skid_ctrl : in_ctrl;
      head_data <= skid_v ? skid_data : in_data;
    end
    if (skid_ld) begin
      skid_ctrl <= in_ctrl;
      skid_data <= in_data;
    end
  end
  assign in_ready  = ~skid_v;
  assign out_valid = head_v;
  assign out_ctrl  = head_v ? head_ctrl : BUBBLE_CTRL;
  assign out_data  = head_data;
  assign occupancy = {1'b0, head_v} + {1'b0, skid_v};
endmodule

// File: tb/tb_pr_stage_skid.sv
// tb_pr_stage_skid: directed checks of streaming, backpressure, flush and async reset.
module tb_pr_stage_skid;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0;
  logic [3:0] in_ctrl = '0, out_ctrl;
  logic [7:0] in_data = '0, out_data;
  logic [1:0] occupancy;
  int         checks = 0, errors = 0;
  pr_stage_skid #(.CTRL_W(4), .DATA_W(8), .BUBBLE_CTRL(4'hA)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic offer(input logic v, input logic [3:0] c);
    in_valid = v;
    in_ctrl  = c;
    in_data  = {c, ~c};
  endtask
  task automatic state(input string tag, input logic v, input logic [3:0] c, input logic [1:0] o, input logic r);
    chk({tag, ".valid"}, out_valid, v);
    chk({tag, ".ctrl"}, out_ctrl, c);
    chk({tag, ".occ"}, occupancy, o);
    chk({tag, ".ready"}, in_ready, r);
  endtask
  task automatic fill2(input logic [3:0] a, input logic [3:0] b);
    out_ready = 1'b0;
    offer(1'b1, a);
    tick;
    offer(1'b1, b);
    tick;
    offer(1'b0, 4'h0);
  endtask
  initial begin
    tick;
    state("reset", 1'b0, 4'hA, 2'd0, 1'b1);
    tick;
    rst_n = 1'b1;
    tick;
    state("idle", 1'b0, 4'hA, 2'd0, 1'b1);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      offer(1'b1, 4'(i));
      tick;
      state($sformatf("stream%0d", i), 1'b1, 4'(i), 2'd1, 1'b1);
      chk($sformatf("stream%0d.data", i), out_data, {4'(i), ~4'(i)});
    end
    offer(1'b0, 4'h0);
    tick;
    state("stream_end", 1'b0, 4'hA, 2'd0, 1'b1);
    out_ready = 1'b0;
    offer(1'b1, 4'h3);
    tick;
    state("bp_a", 1'b1, 4'h3, 2'd1, 1'b1);
    offer(1'b1, 4'h5);
    tick;
    state("bp_ab", 1'b1, 4'h3, 2'd2, 1'b0);
    offer(1'b1, 4'h7);
    tick;
    state("bp_hold", 1'b1, 4'h3, 2'd2, 1'b0);
    offer(1'b0, 4'h0);
    out_ready = 1'b1;
    tick;
    state("bp_b", 1'b1, 4'h5, 2'd1, 1'b1);
    chk("bp_b.data", out_data, 8'h5A);
    tick;
    state("bp_empty", 1'b0, 4'hA, 2'd0, 1'b1);
    fill2(4'h6, 4'h7);
    out_ready = 1'b1;
    offer(1'b1, 4'h9);
    chk("sim.ready_low", in_ready, 1'b0);
    tick;
    state("sim_next", 1'b1, 4'h7, 2'd1, 1'b1);
    offer(1'b0, 4'h0);
    tick;
    state("sim_nodup", 1'b0, 4'hA, 2'd0, 1'b1);
    fill2(4'h1, 4'h2);
    state("fl_full", 1'b1, 4'h1, 2'd2, 1'b0);
    flush = 1'b1;
    offer(1'b1, 4'hC);
    tick;
    flush = 1'b0;
    offer(1'b0, 4'h0);
    state("flush", 1'b0, 4'hA, 2'd0, 1'b1);
    out_ready = 1'b1;
    tick;
    state("flush_noC", 1'b0, 4'hA, 2'd0, 1'b1);
    fill2(4'h4, 4'h5);
    state("ar_full", 1'b1, 4'h4, 2'd2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    state("async_rst", 1'b0, 4'hA, 2'd0, 1'b1);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    offer(1'b1, 4'h8);
    tick;
    state("post_rst", 1'b1, 4'h8, 2'd1, 1'b1);
    offer(1'b0, 4'h0);
    tick;
    state("post_rst_end", 1'b0, 4'hA, 2'd0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
